// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: picks the next PC, stalls the PC register, runs the
// instruction-memory handshake and raises a fetch fault after a memory timeout.
module fetch_sequencer #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned FAULT_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            pcf,
  output logic [31:0]            pc_next,
  output logic                   pc_stall,
  output logic                   imem_req,
  input  logic                   imem_ready,
  output logic                   if_valid,
  input  logic                   hazard_stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  input  logic                   trap,
  output logic                   flush_d,
  output logic                   fetch_fault,
  output logic [FAULT_CNT_W-1:0] fault_count
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HELD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_nxt;
  logic              fault_inc;
  logic [31:0]       pc_plus4;

  // Sequential PC wraps modulo 2^32.
  assign pc_plus4 = pcf + 32'd4;

  // State, wait counter and saturating fault counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      wcnt        <= '0;
      fault_count <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (fault_inc && (fault_count != '1)) begin
        fault_count <= fault_count + FAULT_CNT_W'(1);
      end
    end
  end

  // Next state and Mealy outputs; stalled cycles always present pcf as pc_next.
  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    pc_next     = pcf;
    pc_stall    = 1'b1;
    imem_req    = 1'b0;
    if_valid    = 1'b0;
    flush_d     = 1'b0;
    fetch_fault = 1'b0;
    fault_inc   = 1'b0;

    if (state == BOOT) begin
      state_nxt = FETCH;
      wcnt_nxt  = '0;
    end else begin
      // The fault report survives a same-cycle trap or redirect.
      if (state == FAULT) begin
        fetch_fault = 1'b1;
        fault_inc   = 1'b1;
      end

      if (trap || redirect_valid) begin
        pc_next   = trap ? TRAP_VECTOR : redirect_target;
        pc_stall  = 1'b0;
        flush_d   = 1'b1;
        state_nxt = FETCH;
        wcnt_nxt  = '0;
      end else begin
        case (state)
          FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
              if_valid = 1'b1;
              wcnt_nxt = '0;
              if (hazard_stall) begin
                state_nxt = HELD;
              end else begin
                pc_next  = pc_plus4;
                pc_stall = 1'b0;
              end
            end else if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
              state_nxt = FAULT;
              wcnt_nxt  = '0;
            end else begin
              wcnt_nxt = wcnt + WCNT_W'(1);
            end
          end
          HELD: begin
            if_valid = 1'b1;
            if (!hazard_stall) begin
              pc_next   = pc_plus4;
              pc_stall  = 1'b0;
              state_nxt = FETCH;
            end
          end
          FAULT: begin
            pc_next   = TRAP_VECTOR;
            pc_stall  = 1'b0;
            flush_d   = 1'b1;
            state_nxt = FETCH;
            wcnt_nxt  = '0;
          end
          default: begin
            state_nxt = BOOT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: hand-derived vector table, directed corner sequences
// and randomized traffic against an event-level reference model.
module tb_fetch_sequencer;

  localparam logic [31:0] TV      = 32'h0000_0100;
  localparam int          TIMEOUT = 15;
  localparam int          FMAX    = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pcf = 32'd0;
  logic [31:0] redirect_target = 32'd0;
  logic        imem_ready = 1'b0;
  logic        hazard_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] pc_next;
  logic        pc_stall, imem_req, if_valid, flush_d, fetch_fault;
  logic [7:0]  fault_count;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.TRAP_VECTOR(TV), .TIMEOUT(TIMEOUT), .FAULT_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .pcf(pcf), .pc_next(pc_next), .pc_stall(pc_stall),
    .imem_req(imem_req), .imem_ready(imem_ready), .if_valid(if_valid),
    .hazard_stall(hazard_stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap(trap), .flush_d(flush_d),
    .fetch_fault(fetch_fault), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] next;
    logic        stall, req, valid, flush, fault;
  } exp_t;

  typedef struct {
    bit          set_pc;
    logic [31:0] pc;
    logic        t, r;
    logic [31:0] tgt;
    logic        rdy, hz;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];

  // Reference model: boot pending, instruction held, fault pending, miss run, fault total.
  bit m_boot, m_held, m_fault;
  int m_miss, m_faults;

  function automatic void addv(bit sp, logic [31:0] pc, logic t, logic r, logic [31:0] tgt,
                               logic rdy, logic hz, logic [31:0] nx, logic st, logic rq,
                               logic vl, logic fl, logic ff);
    vec_t v;
    v.set_pc = sp; v.pc = pc; v.t = t; v.r = r; v.tgt = tgt; v.rdy = rdy; v.hz = hz;
    v.e = '{next: nx, stall: st, req: rq, valid: vl, flush: fl, fault: ff};
    vecs.push_back(v);
  endfunction

  task automatic check_outs(input string tag, input exp_t e, input logic [7:0] fc);
    logic [45:0] got, want;
    got  = {pc_next, pc_stall, imem_req, if_valid, flush_d, fetch_fault, fault_count};
    want = {e.next, e.stall, e.req, e.valid, e.flush, e.fault, fc};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got next=%h stall=%b req=%b valid=%b flush=%b fault=%b cnt=%0d, expected next=%h stall=%b req=%b valid=%b flush=%b fault=%b cnt=%0d",
               tag, pc_next, pc_stall, imem_req, if_valid, flush_d, fetch_fault, fault_count,
               e.next, e.stall, e.req, e.valid, e.flush, e.fault, fc);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic drive(input logic t, input logic r, input logic [31:0] tgt,
                       input logic rdy, input logic hz);
    trap = t; redirect_valid = r; redirect_target = tgt; imem_ready = rdy; hazard_stall = hz;
  endtask

  // Predicts this cycle's outputs from the current inputs and advances the model.
  task automatic model_step(output exp_t e);
    e = '{next: pcf, stall: 1'b1, req: 1'b0, valid: 1'b0, flush: 1'b0, fault: 1'b0};
    if (m_boot) begin
      m_boot = 0; m_held = 0; m_fault = 0; m_miss = 0;
      return;
    end
    if (m_fault) begin
      e.fault = 1'b1;
      if (m_faults < FMAX) m_faults++;
    end
    if (trap || redirect_valid) begin
      e.next = trap ? TV : redirect_target;
      e.stall = 1'b0; e.flush = 1'b1;
      m_held = 0; m_fault = 0; m_miss = 0;
    end else if (m_fault) begin
      e.next = TV; e.stall = 1'b0; e.flush = 1'b1;
      m_fault = 0; m_miss = 0;
    end else if (m_held) begin
      e.valid = 1'b1;
      if (!hazard_stall) begin
        e.next = pcf + 32'd4; e.stall = 1'b0; m_held = 0;
      end
    end else begin
      e.req = 1'b1;
      if (imem_ready) begin
        e.valid = 1'b1; m_miss = 0;
        if (hazard_stall) m_held = 1;
        else begin e.next = pcf + 32'd4; e.stall = 1'b0; end
      end else begin
        m_miss++;
        if (m_miss == TIMEOUT) begin m_fault = 1; m_miss = 0; end
      end
    end
  endtask

  task automatic run_cycle(input string tag);
    exp_t e;
    logic [7:0] fc;
    fc = 8'(m_faults);
    model_step(e);
    @(negedge clk);
    check_outs(tag, e, fc);
    @(posedge clk); #1;
    if (!e.stall) pcf = e.next;
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    reset = 1'b1;
    #1;
    e = '{next: pcf, stall: 1'b1, req: 1'b0, valid: 1'b0, flush: 1'b0, fault: 1'b0};
    check_outs(tag, e, 8'd0);
    m_boot = 1; m_held = 0; m_fault = 0; m_miss = 0; m_faults = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int burst;
    //    sp pc            t r tgt           rdy hz next          st rq vl fl ff
    addv(0, 0,            1,1,32'h80,       1,0, 32'h0,        1,0,0,0,0); // BOOT ignores trap/redirect
    addv(0, 0,            0,0,0,            1,0, 32'h4,        0,1,1,0,0);
    addv(0, 0,            0,0,0,            1,0, 32'h8,        0,1,1,0,0);
    addv(0, 0,            0,0,0,            1,0, 32'hC,        0,1,1,0,0);
    addv(0, 0,            0,0,0,            1,0, 32'h10,       0,1,1,0,0);
    addv(1, 32'h8,        0,0,0,            0,0, 32'h8,        1,1,0,0,0); // memory wait
    addv(0, 0,            0,0,0,            0,0, 32'h8,        1,1,0,0,0);
    addv(0, 0,            0,0,0,            1,0, 32'hC,        0,1,1,0,0);
    addv(1, 32'h4,        0,0,0,            1,1, 32'h4,        1,1,1,0,0); // hazard -> HELD
    addv(0, 0,            0,0,0,            1,1, 32'h4,        1,0,1,0,0);
    addv(0, 0,            0,0,0,            1,1, 32'h4,        1,0,1,0,0);
    addv(0, 0,            0,0,0,            1,0, 32'h8,        0,0,1,0,0);
    addv(0, 0,            0,0,0,            1,0, 32'hC,        0,1,1,0,0);
    addv(1, 32'h20,       0,0,0,            0,0, 32'h20,       1,1,0,0,0);
    addv(0, 0,            0,1,32'h40,       0,0, 32'h40,       0,0,0,1,0); // redirect in wait
    addv(0, 0,            0,0,0,            1,0, 32'h44,       0,1,1,0,0);
    addv(0, 0,            1,1,32'h80,       1,0, TV,           0,0,0,1,0); // trap beats redirect
    addv(1, 32'hFFFF_FFFC,0,0,0,            1,0, 32'h0,        0,1,1,0,0); // wrap
    addv(0, 0,            0,1,32'h200,      1,0, 32'h200,      0,0,0,1,0); // ready ignored
    addv(0, 0,            0,0,0,            1,1, 32'h200,      1,1,1,0,0);
    addv(0, 0,            1,0,0,            1,1, TV,           0,0,0,1,0); // trap while HELD
    addv(0, 0,            0,0,0,            1,0, 32'h104,      0,1,1,0,0);

    pcf = 32'd0;
    do_reset("reset_initial");
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].set_pc) pcf = vecs[i].pc;
      drive(vecs[i].t, vecs[i].r, vecs[i].tgt, vecs[i].rdy, vecs[i].hz);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].e, 8'd0);
      @(posedge clk); #1;
      if (!vecs[i].e.stall) pcf = vecs[i].e.next;
    end

    // Redirect during a wait clears the miss run; 14 further misses must not fault.
    pcf = 32'd0;
    do_reset("reset_seq");
    drive(0, 0, 0, 1, 0); run_cycle("boot");
    pcf = 32'h20;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) run_cycle("wait_pre_redirect");
    drive(0, 1, 32'h40, 0, 0); run_cycle("redirect_in_wait");
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) run_cycle("wait_after_redirect");
    drive(0, 0, 0, 1, 0); run_cycle("ready_after_14");
    check_val("no_fault_after_redirect", 32'(fault_count), 32'd0);

    // Redirect in the FAULT cycle overrides pc_next but the fault still counts.
    pcf = 32'h10;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) run_cycle("timeout_wait");
    drive(0, 1, 32'h80, 0, 0); run_cycle("fault_with_redirect");
    check_val("fault_count_one", 32'(fault_count), 32'd1);

    // Continuous misses: one fault per TIMEOUT+1 cycles, counter saturates.
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < (TIMEOUT + 1) * 260; i++) run_cycle("timeout_saturate");
    check_val("fault_count_saturated", 32'(fault_count), 32'd255);

    // Reset mid-HELD returns to BOOT and clears the fault counter.
    drive(0, 0, 0, 1, 1); run_cycle("enter_held");
    run_cycle("in_held");
    do_reset("reset_mid_held");
    check_val("fault_count_after_reset", 32'(fault_count), 32'd0);

    drive(0, 0, 0, 1, 0); run_cycle("boot2");
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom & 32'hFFFF_FFFC;
      if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(10, 20);
      if ($urandom_range(0, 49) == 0) pcf = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      drive($urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0, tgt,
            (burst > 0) ? 1'b0 : ($urandom_range(0, 9) < 7), $urandom_range(0, 3) == 0);
      if (burst > 0) begin
        burst--;
        trap = 1'b0; redirect_valid = 1'b0;
      end
      run_cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
